// File: rtl/octopos_mbox_reader.sv
// octopos_mbox_reader
//
// Drains one mailbox message over AXI4-Lite whenever the mailbox interrupt is
// raised. It issues MSG_WORDS single-beat reads to the fixed address RD_ADDR, one
// read in flight at a time. Each good word is presented on a valid/ready output
// stream, and the final word of the message is marked with m_last. A read that
// returns a non-OKAY response aborts the message and raises the sticky err flag.
//
// Parameters:
//   MSG_WORDS  words fetched per interrupt (1..255)
//   RD_ADDR    read address of the mailbox data port
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   irq                  level interrupt, "message readable"
//   m_axi_ar*            AXI4-Lite read address channel (master side)
//   m_axi_r*             AXI4-Lite read data channel (master side)
//   m_data/m_valid/
//   m_ready/m_last       output word stream
//   err, err_clr         sticky bad-response flag and its clear
//   busy                 high whenever a message is being fetched
//   msg_count            completed-message counter
//                        (only with OCTOPOS_MBOX_READER_STATS_EN defined)
//
// Optional feature macro: OCTOPOS_MBOX_READER_STATS_EN
module octopos_mbox_reader #(
  parameter int unsigned MSG_WORDS = 16,
  parameter logic [31:0] RD_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        err,
  input  logic        err_clr,
`ifdef OCTOPOS_MBOX_READER_STATS_EN
  output logic [15:0] msg_count,
`endif
  output logic        busy
);

  localparam logic [7:0] LastIdx = 8'(MSG_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR,
    StOut
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    valid_d       = valid_q;
    last_d        = last_q;
    // A clear is overridden below if a bad response lands in the same cycle.
    err_d         = err_q & ~err_clr;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (irq && !valid_q) begin
          state_d = StAr;
          cnt_d   = '0;
        end
      end
      StAr: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = StR;
        end
      end
      StR: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          if (m_axi_rresp == 2'b00) begin
            data_d  = m_axi_rdata;
            valid_d = 1'b1;
            last_d  = (cnt_q == LastIdx);
            state_d = StOut;
          end else begin
            // Bad response: drop the word and abandon the rest of the message.
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StOut: begin
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = StAr;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign m_axi_araddr = RD_ADDR;
  assign m_data       = data_q;
  assign m_valid      = valid_q;
  assign m_last       = last_q;
  assign err          = err_q;
  assign busy         = (state_q != StIdle);

`ifdef OCTOPOS_MBOX_READER_STATS_EN
  logic [15:0] msg_count_q;

  // Counts only messages whose last word was handed off; aborts never get here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      msg_count_q <= '0;
    end else if (state_q == StOut && valid_q && m_ready && last_q) begin
      msg_count_q <= msg_count_q + 16'd1;
    end
  end

  assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_octopos_mbox_reader.sv
// tb_octopos_mbox_reader
//
// Bench for octopos_mbox_reader with MSG_WORDS=4. The bench acts as an
// AXI4-Lite slave and as a stream sink. A transaction-level model tracks the
// following state:
//   - the expected word queue
//   - the word position within the current message
//   - the sticky error flag
//   - the number of completed messages
// The DUT outputs are checked against this model at every falling edge.
// Directed scenarios pin the model with literal word sequences and timings.
// A randomized phase follows the directed scenarios.
module tb_octopos_mbox_reader;

  localparam int          Words = 4;
  localparam logic [31:0] Addr  = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        irq, arvalid, arready, rvalid, rready;
  logic        m_valid, m_ready, m_last, err, err_clr, busy;
  logic [31:0] araddr, rdata, m_data;
  logic [1:0]  rresp;
`ifdef OCTOPOS_MBOX_READER_STATS_EN
  logic [15:0] msg_count;
`endif

  always #5 clk = ~clk;

  octopos_mbox_reader #(
    .MSG_WORDS(Words),
    .RD_ADDR  (Addr)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .irq          (irq),
    .m_axi_araddr (araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .err          (err),
    .err_clr      (err_clr),
`ifdef OCTOPOS_MBOX_READER_STATS_EN
    .msg_count    (msg_count),
`endif
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idx;
  } word_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  word_t exp_q[$];
  int    msg_idx;
  logic  err_exp;
  int    done_msgs;
  logic  rd_pending;
  int    ar_wait, r_wait;
  logic  prev_ar_stall, prev_idle, prev_irq;
  int    cyc = 0;

  // Stimulus knobs
  logic  irq_k = 1'b0, err_clr_k = 1'b0, rand_mode = 1'b0, clr_on_rerr = 1'b0;
  int    ar_dly = 0, r_dly = 0, err_idx = -1, stall_idx = -1, stall_len = 0, stall_seen = 0;
  int    err_pct = 5, mready_pct = 70;

  // Handoff log for the literal checks
  logic [31:0] log_data[$];
  logic        log_last[$];
  int          log_cyc[$];
  int          irq_cyc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    msg_idx       = 0;
    err_exp       = 1'b0;
    done_msgs     = 0;
    rd_pending    = 1'b0;
    ar_wait       = 0;
    r_wait        = 0;
    prev_ar_stall = 1'b0;
    prev_idle     = 1'b0;
    prev_irq      = 1'b0;
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  // One clock period: check outputs against the model at the falling edge,
  // drive the inputs, then advance the model by the handshakes the coming
  // rising edge will perform.
  task automatic step();
    word_t w;
    logic  hs_ar, hs_r, hs_m;
    @(negedge clk);
    cyc++;
    check32("araddr", araddr, Addr);
    check1("m_valid", m_valid, exp_q.size() != 0);
    if (m_valid && exp_q.size() != 0) begin
      check32("m_data", m_data, exp_q[0].data);
      check1("m_last", m_last, exp_q[0].last);
    end
    check1("err", err, err_exp);
    check1("busy", busy, arvalid | rready | m_valid);
    if (arvalid) check1("ar_exclusive", rd_pending | m_valid, 1'b0);
    if (rready) check1("r_outstanding", rd_pending, 1'b1);
    if (prev_ar_stall) check1("arvalid_held", arvalid, 1'b1);
    if (prev_idle) begin
      check1("idle_exit", busy, prev_irq);
      if (prev_irq) check1("irq_to_arvalid", arvalid, 1'b1);
    end
`ifdef OCTOPOS_MBOX_READER_STATS_EN
    check32("msg_count", 32'(msg_count), 32'(done_msgs));
`endif

    irq = irq_k;
    arready = 1'b0;
    if (arvalid && !rd_pending) begin
      if (ar_wait >= ar_dly) arready = 1'b1;
      else ar_wait++;
    end
    rvalid = 1'b0;
    rresp  = 2'b00;
    rdata  = 32'h0;
    if (rd_pending) begin
      if (r_wait >= r_dly) begin
        rvalid = 1'b1;
        rdata  = rand_mode ? $urandom : 32'(32'hA0 + msg_idx);
        if (rand_mode ? ($urandom_range(99) < err_pct) : (msg_idx == err_idx))
          rresp = rand_mode ? 2'(1 + $urandom_range(2)) : 2'b10;
      end else begin
        r_wait++;
      end
    end
    err_clr = err_clr_k | (rand_mode && ($urandom_range(99) < 5)) |
              (clr_on_rerr && rvalid && rresp != 2'b00);
    m_ready = 1'b1;
    if (rand_mode) begin
      m_ready = ($urandom_range(99) < mready_pct);
    end else if (m_valid && exp_q.size() != 0 && exp_q[0].idx == stall_idx &&
                 stall_seen < stall_len) begin
      m_ready = 1'b0;
      stall_seen++;
    end

    hs_ar = arvalid && arready;
    hs_r  = rvalid && rready;
    hs_m  = m_valid && m_ready;
    if (hs_m && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      log_data.push_back(m_data);
      log_last.push_back(m_last);
      log_cyc.push_back(cyc);
      if (w.last) done_msgs++;
    end
    if (hs_ar) begin
      rd_pending = 1'b1;
      ar_wait    = 0;
      if (rand_mode) r_dly = $urandom_range(0, 3);
    end
    if (hs_r) begin
      rd_pending = 1'b0;
      r_wait     = 0;
      if (rand_mode) ar_dly = $urandom_range(0, 3);
      if (rresp == 2'b00) begin
        exp_q.push_back('{data: rdata, last: (msg_idx == Words - 1), idx: msg_idx});
        msg_idx = (msg_idx == Words - 1) ? 0 : msg_idx + 1;
      end else begin
        msg_idx = 0;
      end
    end
    if (hs_r && rresp != 2'b00) err_exp = 1'b1;
    else if (err_clr) err_exp = 1'b0;
    prev_ar_stall = arvalid && !arready;
    prev_idle     = !busy;
    prev_irq      = irq;
  endtask

  task automatic pulse_irq();
    irq_k = 1'b1;
    step();
    irq_k = 1'b0;
    irq_cyc = cyc;
  endtask

  task automatic run_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: still busy after 300 cycles, expected idle", name);
  endtask

  task automatic check_msg(input string name);
    check32({name, "_len"}, 32'(log_data.size()), 32'(Words));
    for (int i = 0; i < log_data.size() && i < Words; i++) begin
      check32({name, "_data"}, log_data[i], 32'(32'hA0 + i));
      check1({name, "_last"}, log_last[i], i == Words - 1);
    end
  endtask

  task automatic reset_vals(input string name);
    check1({name, "_m_valid"}, m_valid, 1'b0);
    check1({name, "_m_last"}, m_last, 1'b0);
    check32({name, "_m_data"}, m_data, 32'h0);
    check1({name, "_arvalid"}, arvalid, 1'b0);
    check1({name, "_rready"}, rready, 1'b0);
    check1({name, "_err"}, err, 1'b0);
    check1({name, "_busy"}, busy, 1'b0);
`ifdef OCTOPOS_MBOX_READER_STATS_EN
    check32({name, "_msg_count"}, 32'(msg_count), 32'h0);
`endif
  endtask

  task automatic reset_now(input string name);
    resetn = 1'b0;
    #1;
    reset_vals(name);
    model_reset();
    arready = 1'b0;
    rvalid  = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    irq = 1'b0; err_clr = 1'b0; arready = 1'b0; rvalid = 1'b0;
    rdata = 32'h0; rresp = 2'b00; m_ready = 1'b1;
    model_reset();
    #2;
    reset_now("por");
    repeat (3) step();

    // Basic message, all handshakes immediate
    clear_log();
    pulse_irq();
    run_idle("basic");
    check_msg("basic");
    if (log_cyc.size() == Words) begin
      check32("first_latency", 32'(log_cyc[0] - irq_cyc), 32'd3);
      for (int i = 1; i < Words; i++)
        check32("word_period", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
      check32("busy_fall", 32'(cyc), 32'(log_cyc[Words-1] + 1));
    end

    // Sink stalls five cycles on the second word
    clear_log();
    stall_idx = 1; stall_len = 5; stall_seen = 0;
    pulse_irq();
    run_idle("stall");
    check_msg("stall");
    check32("stall_cycles", 32'(stall_seen), 32'd5);
    stall_idx = -1;

    // Bad response on the second read, with a clear landing in the same cycle
    clear_log();
    err_idx = 1; clr_on_rerr = 1'b1;
    pulse_irq();
    run_idle("abort");
    check32("abort_len", 32'(log_data.size()), 32'd1);
    if (log_data.size() > 0) check32("abort_word0", log_data[0], 32'hA0);
    check1("err_set", err, 1'b1);
    check1("abort_idle", busy, 1'b0);
    err_idx = -1; clr_on_rerr = 1'b0;
    err_clr_k = 1'b1;
    step();
    err_clr_k = 1'b0;
    step();
    check1("err_cleared", err, 1'b0);

    // Slow slave: arready after three cycles, rvalid after two
    clear_log();
    ar_dly = 3; r_dly = 2;
    pulse_irq();
    run_idle("slow");
    check_msg("slow");

    // Reset while the second read is in its data phase
    ar_dly = 0; r_dly = 2;
    pulse_irq();
    for (int i = 0; i < 100; i++) begin
      step();
      if (rready && !rvalid && msg_idx == 1) break;
    end
    check1("reached_r_word2", rready, 1'b1);
    reset_now("mid_reset");
    r_dly = 0;
    step();
    clear_log();
    pulse_irq();
    run_idle("after_reset");
    check_msg("after_reset");

    // Two more completed messages and one aborted message
    pulse_irq();
    run_idle("msg2");
    pulse_irq();
    run_idle("msg3");
    err_idx = 2;
    pulse_irq();
    run_idle("msg_abort");
    err_idx = -1;
    err_clr_k = 1'b1;
    step();
    err_clr_k = 1'b0;
    step();
`ifdef OCTOPOS_MBOX_READER_STATS_EN
    check32("stats_count", 32'(msg_count), 32'd3);
`endif

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      irq_k = ($urandom_range(99) < 30);
      step();
    end
    irq_k = 1'b0;
    run_idle("drain");
    rand_mode = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
